clock_run_controller: RTL and testbench
=======================================

Name: clock_run_controller

Overview:
- Sequences the run enable of the system clock generator (the existing 50%-duty PWM clock with an enable pin) and any gated core clock.
- Accepts start / stop / single-step / burst-N requests from the testbench or debug logic, plus a halt request from the core (halt instruction).
- Produces a registered clock enable, a cycle counter and status.
- Sits between the top-level harness and the clock generator's enable input.

Parameters:
CNT_WIDTH, 32, width of burst_len and cycle_count
MAX_RUN, 0, watchdog limit on continuous RUN cycles; 0 disables the watchdog

Ports:
clk  input  1  free-running controller clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request free run (level sampled each edge)
stop  input  1  request return to IDLE
step  input  1  request exactly one enabled cycle
burst  input  1  request burst_len enabled cycles
burst_len  input  CNT_WIDTH  burst length, sampled only when the burst request is accepted
halt_req  input  1  halt from core
clr_count  input  1  synchronous clear of cycle_count
clk_en  output  1  enable to clock generator / core clock gate
state  output  3  current state (encoding from package)
cycle_count  output  CNT_WIDTH  number of cycles with clk_en=1
done  output  1  one-cycle pulse on leaving an active state
timeout  output  1  sticky watchdog flag

Behaviour:
- Reset: clock and reset are the single clk and the asynchronous active-low rst_n (decided, as above). While rst_n=0: state=IDLE, clk_en=0, cycle_count=0, done=0, timeout=0, remaining=0. Reset asserted mid-RUN/BURST/STEP aborts immediately; no done pulse.
- States: IDLE, RUN, BURST, STEP, HALTED.
- Moore outputs: clk_en = (state is RUN, BURST or STEP). A request accepted at edge k gives clk_en=1 in the cycle after edge k.
- IDLE transitions, priority halt_req > stop > step > burst > start:
  - halt_req -> HALTED.
  - stop -> stay IDLE.
  - step -> STEP.
  - burst with burst_len != 0 -> BURST, remaining <= burst_len.
  - burst with burst_len == 0 -> ignored, no done.
  - start -> RUN.
- STEP: exactly one cycle, then IDLE with done=1 in the following cycle. halt_req during STEP -> HALTED instead.
- BURST:
  - remaining decrements each cycle; the last cycle is the one with remaining==1, then -> IDLE, done pulse. clk_en is high for exactly burst_len cycles.
  - stop -> IDLE early; halt_req -> HALTED early. Both pulse done.
- RUN:
  - stop -> IDLE, done. halt_req -> HALTED, done. halt_req wins over simultaneous stop.
  - start, step and burst are ignored in RUN and BURST.
  - Watchdog: a run counter resets on RUN entry. If MAX_RUN != 0 and RUN has lasted MAX_RUN cycles, -> HALTED, timeout<=1, done. clk_en is high for exactly MAX_RUN cycles.
- HALTED: clk_en=0.
  - start -> RUN and clears timeout.
  - stop -> IDLE, timeout held.
  - Other requests are ignored.
- done: registered, high for one cycle after any transition from RUN, BURST or STEP to IDLE or HALTED.
- cycle_count:
  - Increments in every cycle with clk_en=1 and saturates at all-ones (no wrap).
  - clr_count has priority over a simultaneous increment: the result is 0.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package clock_ctrl_pkg:
  - state_t enum (3 bits): IDLE=0, RUN=1, BURST=2, STEP=3, HALTED=4.
  - Default CNT_WIDTH localparam.
- Sub-module sat_counter: CNT_WIDTH saturating up-counter with inc and clr inputs and clr priority. Used for cycle_count; the watchdog run counter uses a second instance.
- The FSM and burst down-counter stay in the top-level module.

Test Plan:
- Reset, then step pulse at edge 3 -> clk_en high for exactly 1 cycle (edge 3 to 4); done pulse next cycle; cycle_count=1; state back to IDLE.
- burst=1 with burst_len=5 -> clk_en high 5 cycles, cycle_count=5, one done pulse; repeat with burst_len=0 -> no clk_en, no done.
- start, hold 10 cycles, then stop and halt_req on the same edge -> clk_en high 10 cycles, state=HALTED, done pulse, cycle_count=10; then stop -> IDLE.
- MAX_RUN=8, start -> clk_en high exactly 8 cycles, state=HALTED, timeout=1; start again -> RUN, timeout=0.
- CNT_WIDTH=4, run 20 cycles -> cycle_count saturates at 15; clr_count during an active cycle -> reads 0 next cycle.
- rst_n low asynchronously mid-burst (remaining=3) -> clk_en=0 and state=IDLE immediately, no done; after release, step works normally.

Source files
------------

// File: rtl/clock_ctrl_pkg.sv
// Shared types for the clock run controller: state encoding and default widths.
package clock_ctrl_pkg;

  localparam int DEFAULT_CNT_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_BURST  = 3'd2,
    ST_STEP   = 3'd3,
    ST_HALTED = 3'd4
  } state_t;

  // States in which the downstream clock is enabled.
  function automatic logic is_active(input state_t s);
    return (s == ST_RUN) || (s == ST_BURST) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/clock_run_controller_sat_counter.sv
// Saturating up-counter; clear wins over a simultaneous increment.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_clr,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/clock_run_controller.sv
// Run/stop/step/burst sequencer driving the clock generator enable, with cycle
// counting and an optional watchdog on continuous free-run.
module clock_run_controller
  import clock_ctrl_pkg::*;
#(
  parameter int CNT_WIDTH = DEFAULT_CNT_WIDTH,
  parameter int MAX_RUN   = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 step,
  input  logic                 burst,
  input  logic [CNT_WIDTH-1:0] burst_len,
  input  logic                 halt_req,
  input  logic                 clr_count,
  output logic                 clk_en,
  output logic [2:0]           state,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic                 done,
  output logic                 timeout
);

  // Watchdog fires during the MAX_RUN-th RUN cycle (run counter reads MAX_RUN-1).
  localparam logic [CNT_WIDTH-1:0] WD_LAST = CNT_WIDTH'(MAX_RUN - 1);

  state_t               r_state;
  state_t               w_next;
  logic [CNT_WIDTH-1:0] r_remaining;
  logic [CNT_WIDTH-1:0] w_remaining_nxt;
  logic                 r_clk_en;
  logic                 r_done;
  logic                 r_timeout;
  logic                 w_timeout_nxt;
  logic                 w_leaving;
  logic                 w_wd_hit;
  logic                 w_in_run;
  logic [CNT_WIDTH-1:0] w_run_cnt;

  assign w_in_run = (r_state == ST_RUN);
  assign w_wd_hit = (MAX_RUN != 0) && w_in_run && (w_run_cnt == WD_LAST);

  // Requests are levels sampled every edge; there is no handshake back.
  always_comb begin
    w_next          = r_state;
    w_remaining_nxt = r_remaining;
    w_timeout_nxt   = r_timeout;
    case (r_state)
      ST_IDLE: begin
        if (halt_req) begin
          w_next = ST_HALTED;
        end else if (stop) begin
          w_next = ST_IDLE;
        end else if (step) begin
          w_next = ST_STEP;
        end else if (burst && (burst_len != '0)) begin
          w_next          = ST_BURST;
          w_remaining_nxt = burst_len;
        end else if (start) begin
          w_next = ST_RUN;
        end
      end
      ST_STEP: begin
        w_next = halt_req ? ST_HALTED : ST_IDLE;
      end
      ST_BURST: begin
        w_remaining_nxt = r_remaining - CNT_WIDTH'(1);
        if (halt_req) begin
          w_next          = ST_HALTED;
          w_remaining_nxt = '0;
        end else if (stop) begin
          w_next          = ST_IDLE;
          w_remaining_nxt = '0;
        end else if (r_remaining == CNT_WIDTH'(1)) begin
          w_next = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (halt_req) begin
          w_next = ST_HALTED;
        end else if (w_wd_hit) begin
          w_next        = ST_HALTED;
          w_timeout_nxt = 1'b1;
        end else if (stop) begin
          w_next = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (stop) begin
          w_next = ST_IDLE;
        end else if (start) begin
          w_next        = ST_RUN;
          w_timeout_nxt = 1'b0;
        end
      end
      default: begin
        w_next          = ST_IDLE;
        w_remaining_nxt = '0;
      end
    endcase
  end

  assign w_leaving = is_active(r_state) && !is_active(w_next);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_clk_en    <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_remaining <= w_remaining_nxt;
      r_clk_en    <= is_active(w_next);
      r_done      <= w_leaving;
      r_timeout   <= w_timeout_nxt;
    end
  end

  sat_counter #(.W(CNT_WIDTH)) u_cycle_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_inc   (r_clk_en),
    .i_clr   (clr_count),
    .o_count (cycle_count)
  );

  // Held at zero outside RUN so every RUN entry starts a fresh watchdog interval.
  sat_counter #(.W(CNT_WIDTH)) u_run_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_inc   (w_in_run),
    .i_clr   (!w_in_run),
    .o_count (w_run_cnt)
  );

  assign clk_en  = r_clk_en;
  assign state   = r_state;
  assign done    = r_done;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_clock_run_controller.sv
// Self-checking bench: directed scenarios on three parameterisations plus a
// randomized run compared against a cycle-level behavioural model.
`timescale 1ns/1ps
module tb_clock_run_controller;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RUN    = 3'd1;
  localparam logic [2:0] S_BURST  = 3'd2;
  localparam logic [2:0] S_STEP   = 3'd3;
  localparam logic [2:0] S_HALTED = 3'd4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, stop = 1'b0, step = 1'b0, burst = 1'b0;
  logic        halt_req = 1'b0, clr_count = 1'b0;
  logic [31:0] burst_len = '0;

  logic        clk_en_a, done_a, timeout_a;
  logic [2:0]  state_a;
  logic [31:0] count_a;
  logic        clk_en_w, done_w, timeout_w;
  logic [2:0]  state_w;
  logic [31:0] count_w;
  logic        clk_en_n, done_n, timeout_n;
  logic [2:0]  state_n;
  logic [3:0]  count_n;

  int errors = 0;
  int checks = 0;
  int en_tot_a = 0, done_tot_a = 0, en_tot_w = 0, done_tot_w = 0;

  always #5 clk = ~clk;

  clock_run_controller #(.CNT_WIDTH(32), .MAX_RUN(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .burst(burst), .burst_len(burst_len), .halt_req(halt_req), .clr_count(clr_count),
    .clk_en(clk_en_a), .state(state_a), .cycle_count(count_a), .done(done_a),
    .timeout(timeout_a)
  );

  clock_run_controller #(.CNT_WIDTH(32), .MAX_RUN(8)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .burst(burst), .burst_len(burst_len), .halt_req(halt_req), .clr_count(clr_count),
    .clk_en(clk_en_w), .state(state_w), .cycle_count(count_w), .done(done_w),
    .timeout(timeout_w)
  );

  clock_run_controller #(.CNT_WIDTH(4), .MAX_RUN(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .step(step),
    .burst(burst), .burst_len(burst_len[3:0]), .halt_req(halt_req), .clr_count(clr_count),
    .clk_en(clk_en_n), .state(state_n), .cycle_count(count_n), .done(done_n),
    .timeout(timeout_n)
  );

  always @(negedge clk) begin
    if (clk_en_a) en_tot_a++;
    if (done_a)   done_tot_a++;
    if (clk_en_w) en_tot_w++;
    if (done_w)   done_tot_w++;
  end

  task automatic clear_inputs();
    start = 0; stop = 0; step = 0; burst = 0; halt_req = 0; clr_count = 0;
    burst_len = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    checks++; if (state_a !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want %0d", state_a, S_IDLE); end
    checks++; if (clk_en_a !== 1'b0) begin errors++; $display("FAIL reset_clk_en: got %b want 0", clk_en_a); end
    checks++; if (count_a !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done_a); end
    checks++; if (timeout_w !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_w); end
    checks++; if (count_n !== 4'd0) begin errors++; $display("FAIL reset_count_narrow: got %0d want 0", count_n); end
    rst_n = 1;
  endtask

  task automatic test_step();
    int e0, d0;
    do_reset();
    e0 = en_tot_a; d0 = done_tot_a;
    repeat (2) @(negedge clk);
    step = 1;
    @(posedge clk); #1;
    checks++; if (clk_en_a !== 1'b1) begin errors++; $display("FAIL step_latency: got clk_en=%b want 1", clk_en_a); end
    @(negedge clk); step = 0;
    @(posedge clk); #1;
    checks++; if (clk_en_a !== 1'b0 || done_a !== 1'b1) begin errors++; $display("FAIL step_end: got clk_en=%b done=%b want 0 1", clk_en_a, done_a); end
    repeat (3) @(negedge clk);
    checks++; if (en_tot_a - e0 != 1) begin errors++; $display("FAIL step_en_cycles: got %0d want 1", en_tot_a - e0); end
    checks++; if (done_tot_a - d0 != 1) begin errors++; $display("FAIL step_done_pulses: got %0d want 1", done_tot_a - d0); end
    checks++; if (count_a !== 32'd1) begin errors++; $display("FAIL step_count: got %0d want 1", count_a); end
    checks++; if (state_a !== S_IDLE) begin errors++; $display("FAIL step_state: got %0d want %0d", state_a, S_IDLE); end
  endtask

  task automatic test_burst();
    int e0, d0;
    do_reset();
    e0 = en_tot_a; d0 = done_tot_a;
    @(negedge clk); burst = 1; burst_len = 32'd5;
    @(negedge clk); burst = 0; burst_len = 32'd9;
    repeat (8) @(negedge clk);
    checks++; if (en_tot_a - e0 != 5) begin errors++; $display("FAIL burst5_en_cycles: got %0d want 5", en_tot_a - e0); end
    checks++; if (done_tot_a - d0 != 1) begin errors++; $display("FAIL burst5_done: got %0d want 1", done_tot_a - d0); end
    checks++; if (count_a !== 32'd5) begin errors++; $display("FAIL burst5_count: got %0d want 5", count_a); end
    checks++; if (state_a !== S_IDLE) begin errors++; $display("FAIL burst5_state: got %0d want %0d", state_a, S_IDLE); end
    e0 = en_tot_a; d0 = done_tot_a;
    @(negedge clk); burst = 1; burst_len = 32'd0;
    @(negedge clk); burst = 0;
    repeat (4) @(negedge clk);
    checks++; if (en_tot_a - e0 != 0 || done_tot_a - d0 != 0) begin errors++; $display("FAIL burst0_ignored: got en=%0d done=%0d want 0 0", en_tot_a - e0, done_tot_a - d0); end
    checks++; if (state_a !== S_IDLE) begin errors++; $display("FAIL burst0_state: got %0d want %0d", state_a, S_IDLE); end
  endtask

  task automatic test_run_stop_halt();
    int e0, d0;
    do_reset();
    e0 = en_tot_a; d0 = done_tot_a;
    @(negedge clk); start = 1;
    @(posedge clk);
    @(negedge clk); start = 0;
    repeat (9) @(posedge clk);
    @(negedge clk); stop = 1; halt_req = 1;
    @(posedge clk);
    @(negedge clk); stop = 0; halt_req = 0;
    repeat (2) @(negedge clk);
    checks++; if (en_tot_a - e0 != 10) begin errors++; $display("FAIL run_en_cycles: got %0d want 10", en_tot_a - e0); end
    checks++; if (state_a !== S_HALTED) begin errors++; $display("FAIL run_halt_state: got %0d want %0d", state_a, S_HALTED); end
    checks++; if (done_tot_a - d0 != 1) begin errors++; $display("FAIL run_done: got %0d want 1", done_tot_a - d0); end
    checks++; if (count_a !== 32'd10) begin errors++; $display("FAIL run_count: got %0d want 10", count_a); end
    @(negedge clk); stop = 1;
    @(negedge clk); stop = 0;
    checks++; if (state_a !== S_IDLE) begin errors++; $display("FAIL halted_stop_state: got %0d want %0d", state_a, S_IDLE); end
  endtask

  task automatic test_watchdog();
    int e0, d0;
    do_reset();
    e0 = en_tot_w; d0 = done_tot_w;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (12) @(negedge clk);
    checks++; if (en_tot_w - e0 != 8) begin errors++; $display("FAIL wd_en_cycles: got %0d want 8", en_tot_w - e0); end
    checks++; if (state_w !== S_HALTED) begin errors++; $display("FAIL wd_state: got %0d want %0d", state_w, S_HALTED); end
    checks++; if (timeout_w !== 1'b1) begin errors++; $display("FAIL wd_timeout: got %b want 1", timeout_w); end
    checks++; if (done_tot_w - d0 != 1) begin errors++; $display("FAIL wd_done: got %0d want 1", done_tot_w - d0); end
    checks++; if (timeout_a !== 1'b0) begin errors++; $display("FAIL wd_disabled: got timeout=%b want 0", timeout_a); end
    start = 1;
    @(posedge clk); #1;
    checks++; if (state_w !== S_RUN || timeout_w !== 1'b0) begin errors++; $display("FAIL wd_restart: got state=%0d timeout=%b want %0d 0", state_w, timeout_w, S_RUN); end
    @(negedge clk); start = 0; stop = 1;
    @(negedge clk); stop = 0;
  endtask

  task automatic test_saturate();
    do_reset();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (20) @(negedge clk);
    checks++; if (count_n !== 4'd15) begin errors++; $display("FAIL sat_count: got %0d want 15", count_n); end
    checks++; if (clk_en_n !== 1'b1) begin errors++; $display("FAIL sat_still_running: got %b want 1", clk_en_n); end
    clr_count = 1;
    @(posedge clk); #1;
    checks++; if (count_n !== 4'd0) begin errors++; $display("FAIL clr_priority: got %0d want 0", count_n); end
    @(negedge clk); clr_count = 0;
    @(posedge clk); #1;
    checks++; if (count_n !== 4'd1) begin errors++; $display("FAIL clr_resume: got %0d want 1", count_n); end
    @(negedge clk); stop = 1;
    @(negedge clk); stop = 0;
  endtask

  task automatic test_async_reset();
    int e0, d0;
    do_reset();
    d0 = done_tot_a;
    @(negedge clk); burst = 1; burst_len = 32'd6;
    @(posedge clk);
    @(negedge clk); burst = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++; if (clk_en_a !== 1'b1 || state_a !== S_BURST) begin errors++; $display("FAIL abort_pre: got clk_en=%b state=%0d want 1 %0d", clk_en_a, state_a, S_BURST); end
    rst_n = 0;
    #1;
    checks++; if (clk_en_a !== 1'b0 || state_a !== S_IDLE) begin errors++; $display("FAIL abort_immediate: got clk_en=%b state=%0d want 0 %0d", clk_en_a, state_a, S_IDLE); end
    checks++; if (count_a !== 32'd0) begin errors++; $display("FAIL abort_count: got %0d want 0", count_a); end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++; if (done_tot_a != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_tot_a - d0); end
    e0 = en_tot_a; d0 = done_tot_a;
    step = 1;
    @(negedge clk); step = 0;
    repeat (3) @(negedge clk);
    checks++; if (en_tot_a - e0 != 1 || done_tot_a - d0 != 1 || count_a !== 32'd1) begin
      errors++; $display("FAIL abort_then_step: got en=%0d done=%0d count=%0d want 1 1 1", en_tot_a - e0, done_tot_a - d0, count_a);
    end
  endtask

  task automatic test_random();
    logic [2:0] m_state, nxt;
    int         m_left;
    longint     m_count;
    logic       m_done, m_en, was_active;
    do_reset();
    m_state = S_IDLE; m_left = 0; m_count = 0; m_done = 0; m_en = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      start     = ($urandom_range(0, 5) == 0);
      stop      = ($urandom_range(0, 11) == 0);
      step      = ($urandom_range(0, 9) == 0);
      burst     = ($urandom_range(0, 7) == 0);
      halt_req  = ($urandom_range(0, 19) == 0);
      clr_count = ($urandom_range(0, 24) == 0);
      burst_len = 32'($urandom_range(0, 7));
      @(posedge clk);
      nxt = m_state;
      case (m_state)
        S_IDLE: begin
          if (halt_req) nxt = S_HALTED;
          else if (stop) nxt = S_IDLE;
          else if (step) nxt = S_STEP;
          else if (burst && burst_len != 0) begin nxt = S_BURST; m_left = int'(burst_len); end
          else if (start) nxt = S_RUN;
        end
        S_STEP: nxt = halt_req ? S_HALTED : S_IDLE;
        S_BURST: begin
          m_left--;
          if (halt_req) nxt = S_HALTED;
          else if (stop || m_left == 0) nxt = S_IDLE;
        end
        S_RUN: begin
          if (halt_req) nxt = S_HALTED;
          else if (stop) nxt = S_IDLE;
        end
        S_HALTED: begin
          if (stop) nxt = S_IDLE;
          else if (start) nxt = S_RUN;
        end
        default: nxt = S_IDLE;
      endcase
      was_active = m_en;
      if (clr_count) m_count = 0;
      else if (m_en && m_count < 64'hFFFF_FFFF) m_count++;
      m_done  = was_active && (nxt == S_IDLE || nxt == S_HALTED);
      m_state = nxt;
      m_en    = (nxt == S_RUN || nxt == S_BURST || nxt == S_STEP);
      #1;
      checks++;
      if (state_a !== m_state || clk_en_a !== m_en || done_a !== m_done || count_a !== 32'(m_count)) begin
        errors++;
        $display("FAIL random[%0d]: got state=%0d en=%b done=%b count=%0d want state=%0d en=%b done=%b count=%0d",
                 i, state_a, clk_en_a, done_a, count_a, m_state, m_en, m_done, m_count);
      end
    end
    @(negedge clk);
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL time_limit: got no completion want completion");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_step();
    test_burst();
    test_run_stop_halt();
    test_watchdog();
    test_saturate();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
